gpio_bank: RTL

Parametrised general-purpose I/O bank with `CHANNELS` bidirectional pins behind the same `en` / `r_or_w` / `io_addr` peripheral bus as the existing single-bit ports. Each pin has:
- a per-pin direction bit and output latch;
- a metastability synchroniser;
- rising and falling edge detection feeding a sticky, write-1-to-clear interrupt status.

The block sits on the CPU I/O bus and drives a single level `irq` line to the interrupt controller.

---
 rtl/gpio_pkg.sv | 20 ++
 rtl/gpio_pin.sv | 41 ++++
 rtl/gpio_bank.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Register map and bus-direction constants for gpio_bank.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    localparam logic [3:0] GPIO_PIN     = 4'd0;
    localparam logic [3:0] GPIO_OUT     = 4'd1;
    localparam logic [3:0] GPIO_DIR     = 4'd2;
    localparam logic [3:0] GPIO_RISE_EN = 4'd3;
    localparam logic [3:0] GPIO_FALL_EN = 4'd4;
    localparam logic [3:0] GPIO_STATUS  = 4'd5;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage
`default_nettype wire

// File: rtl/gpio_pin.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pin
// Description : One GPIO pin: tristate driver, synchroniser, edge detection.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_pin #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic out_i,
    input  logic dir_i,
    inout  wire  pin_io,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    assign pin_io = dir_i ? out_i : 1'bz;

    // The pad is sampled even while driven so self-generated transitions are seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_io};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule
`default_nettype wire

// File: rtl/gpio_bank.sv
`default_nettype none
// ============================================================================
// Module      : gpio_bank
// Description : Bus-mapped GPIO bank with sticky W1C edge status and level irq.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_bank
    import gpio_pkg::*;
#(
    parameter int BITS        = 16,
    parameter int CHANNELS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                r_or_w,
    input  logic [3:0]          io_addr,
    input  logic [BITS-1:0]     data_in,
    output logic [BITS-1:0]     data_out,
    output logic                rd_valid,
    inout  wire  [CHANNELS-1:0] io_pins,
    output logic                irq
);

    logic [CHANNELS-1:0] out_q,     out_d;
    logic [CHANNELS-1:0] dir_q,     dir_d;
    logic [CHANNELS-1:0] rise_en_q, rise_en_d;
    logic [CHANNELS-1:0] fall_en_q, fall_en_d;
    logic [CHANNELS-1:0] status_q,  status_d;
    logic [BITS-1:0]     data_out_q, data_out_d;
    logic                rd_valid_q;
    logic                irq_q;

    logic [CHANNELS-1:0] w_sync;
    logic [CHANNELS-1:0] w_rise;
    logic [CHANNELS-1:0] w_fall;
    logic [CHANNELS-1:0] w_set;
    logic [CHANNELS-1:0] w_wdata;
    logic [BITS-1:0]     w_rd_mux;
    logic                w_wr;
    logic                w_rd;
    logic                w_unused_data;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_pin
        gpio_pin #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_pin (
            .clk    (clk),
            .rst_n  (rst_n),
            .out_i  (out_q[gi]),
            .dir_i  (dir_q[gi]),
            .pin_io (io_pins[gi]),
            .sync_o (w_sync[gi]),
            .rise_o (w_rise[gi]),
            .fall_o (w_fall[gi])
        );
    end

    assign w_wr          = en && (r_or_w == RW_WRITE);
    assign w_rd          = en && (r_or_w == RW_READ);
    assign w_wdata       = data_in[CHANNELS-1:0];
    assign w_unused_data = ^data_in;
    assign w_set         = (w_rise & rise_en_q) | (w_fall & fall_en_q);

    always_comb begin
        out_d     = out_q;
        dir_d     = dir_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        status_d  = status_q;
        if (w_wr) begin
            case (io_addr)
                GPIO_OUT:     out_d     = w_wdata;
                GPIO_DIR:     dir_d     = w_wdata;
                GPIO_RISE_EN: rise_en_d = w_wdata;
                GPIO_FALL_EN: fall_en_d = w_wdata;
                GPIO_STATUS:  status_d  = status_q & ~w_wdata;
                default:      ;
            endcase
        end
        // New edges are OR-ed in after the clear so a coincident edge survives W1C.
        status_d = status_d | w_set;
    end

    always_comb begin
        w_rd_mux = '0;
        case (io_addr)
            GPIO_PIN:     w_rd_mux[CHANNELS-1:0] = w_sync;
            GPIO_OUT:     w_rd_mux[CHANNELS-1:0] = out_q;
            GPIO_DIR:     w_rd_mux[CHANNELS-1:0] = dir_q;
            GPIO_RISE_EN: w_rd_mux[CHANNELS-1:0] = rise_en_q;
            GPIO_FALL_EN: w_rd_mux[CHANNELS-1:0] = fall_en_q;
            GPIO_STATUS:  w_rd_mux[CHANNELS-1:0] = status_q;
            default:      ;
        endcase
        data_out_d = w_rd ? w_rd_mux : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            dir_q      <= '0;
            rise_en_q  <= '0;
            fall_en_q  <= '0;
            status_q   <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            out_q      <= out_d;
            dir_q      <= dir_d;
            rise_en_q  <= rise_en_d;
            fall_en_q  <= fall_en_d;
            status_q   <= status_d;
            data_out_q <= data_out_d;
            rd_valid_q <= w_rd;
            irq_q      <= |status_q;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
    assign irq      = irq_q;

endmodule
`default_nettype wire
